swt_debounce: RTL and testbench
===============================

# swt_debounce

Synchronizes and debounces the raw Nexys4 DDR slide-switch inputs before they reach the 2-bit + 2-bit adder. The block sits directly upstream of the adder's `swt[3:0]` operand inputs. Each bit is carried through a two-flop synchronizer and then a stable-time filter. The block outputs clean, glitch-free operand bits and a one-cycle change strobe per bit.

## Interface
- `WIDTH`, default 4: number of switch bits filtered; the adder consumes all 4.
- `CNT_MAX`, default 1_000_000: consecutive cycles a new level must hold before it is accepted. This is 10 ms at 100 MHz. Legal range is 2 to 2^24.
- `clk`  in  1: system clock, 100 MHz board oscillator; the only clock in the block.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `swt_raw`  in  WIDTH: asynchronous switch pins.
- `swt_clean`  out  WIDTH: debounced switch levels; drives the adder's `swt` inputs.
- `swt_chg`  out  WIDTH: one-cycle pulse on bit i when `swt_clean[i]` toggles.
- `busy`  out  1: high while any bit's filter counter is nonzero.

## Operation
- Per bit: `s1 <= swt_raw[i]`, then `s2 <= s1`. This is the two-flop synchronizer; no logic sits between the flops.
- Per bit, there is a two-state filter FSM:
  - **STABLE**: `s2 == swt_clean[i]` and `cnt == 0`. If `s2 != swt_clean[i]`, go to PEND with `cnt <= 1`.
  - **PEND**: if `s2 == swt_clean[i]`, this is a bounce back. Set `cnt <= 0` and return to STABLE, with no output change.
  - **PEND, no bounce**: if `cnt == CNT_MAX-1`, set `swt_clean[i] <= s2`, `cnt <= 0`, and `swt_chg[i] <= 1` for one cycle, then go to STABLE. Otherwise set `cnt <= cnt+1`.
- Counter width is `$clog2(CNT_MAX)`. The counter is unsigned, never exceeds `CNT_MAX-1`, and never wraps.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous `swt_chg` bits.
- `swt_chg` is registered and is high for exactly one cycle per accepted toggle. It is 0 in every other cycle.
- `busy` is the OR over all bits of `cnt != 0`, and is registered.
- Reset values:
  - `s1`, `s2`, `swt_clean`, `swt_chg`, `cnt`, `busy`: all 0.
  - FSM: STABLE.
- Reset during PEND discards the pending change. No `swt_chg` is issued.
- Switches that are already high at reset are accepted as a normal 0→1 toggle once they pass the filter, so `swt_chg` pulses for them.

## Timing
- Latency: raw change settles before edge 1. The `swt_clean` update and `swt_chg` pulse are visible after edge `CNT_MAX+2`.
  - 2 cycles come from the synchronizer.
  - `CNT_MAX` cycles come from the filter.
- A bounce at any cycle within the window restarts the full `CNT_MAX` count from the next mismatch.
- A pulse narrower than `CNT_MAX` cycles, measured at `s2`, never reaches `swt_clean`.
- `busy` rises one cycle after `s2` first mismatches. It falls in the same cycle `swt_chg` pulses, or one cycle after a bounce back.
- All outputs are fully registered, with no combinational path from `swt_raw` to any output.

## Configuration
- `SWT_DEBOUNCE_CHG_EN` defined:
  - The `swt_chg` strobe logic is built as above.
  - `busy` is also built.
- Macro undefined:
  - `swt_chg` and `busy` are tied to constant 0 and their registers are removed.
  - `swt_clean` behaviour and latency are unchanged.
- Ports exist in both builds.

## Structure
- Package `swt_pkg` holds:
  - `SWT_WIDTH = 4` and `SWT_CNT_MAX_DEFAULT = 1_000_000`.
  - `SWT_CNT_MAX_SIM = 8`, the bench value.
  - The filter-state enum `swt_state_t {STABLE, PEND}`.
- Sub-module `swt_debounce_bit` holds one bit's synchronizer, counter, FSM and strobe. It has parameter `CNT_MAX` and ports `clk`, `rst`, `raw`, `clean`, `chg`, `pend`.
- The top generates `WIDTH` instances and ORs the `pend` outputs into `busy`.

## Test plan
All cases use `CNT_MAX=8` and `SWT_DEBOUNCE_CHG_EN` defined unless stated.
- **Reset:** hold `rst` 3 cycles with `swt_raw=4'b0000` → `swt_clean=0`, `swt_chg=0`, `busy=0` on every cycle during and after reset.
- **Clean edge:** set `swt_raw=4'b0001` before edge 1 and hold it → `swt_clean=4'b0001` after edge 10, with `swt_chg=4'b0001` for exactly that one cycle.
- **Bounce reject:** toggle bit 1 high for 5 cycles, low for 2, then high and hold → no change until 8 stable cycles at `s2`. Then `swt_clean[1]=1`, a single `swt_chg[1]` pulse, and `busy` drops the same cycle.
- **Simultaneous bits:** set `swt_raw` 0→4'b1111 at once → all four clean bits update on the same edge, with `swt_chg=4'b1111` for 1 cycle. The adder output then reads 3+3 = `led=3'b110`.
- **Reset mid-PEND:** assert `rst` 4 cycles into a pending bit-2 change → `swt_clean[2]` stays 0 with no pulse. After release, the change is re-accepted 10 cycles later.
- **Macro off:** run the clean-edge case with `SWT_DEBOUNCE_CHG_EN` undefined → identical `swt_clean` timing; `swt_chg` and `busy` are constant 0.

Source files
------------

// File: rtl/swt_debounce_pkg.sv
// Shared types and constants for the slide-switch debouncer.
package swt_pkg;

  localparam int unsigned SWT_WIDTH           = 4;
  localparam int unsigned SWT_CNT_MAX_DEFAULT = 1_000_000;
  localparam int unsigned SWT_CNT_MAX_SIM     = 8;

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } swt_state_t;

endpackage

// File: rtl/swt_debounce_if.sv
// Switch bundle between the board pins, the debouncer and the adder operands.
interface swt_debounce_if #(
  parameter int unsigned WIDTH = swt_pkg::SWT_WIDTH
);

  logic [WIDTH-1:0] swt_raw;
  logic [WIDTH-1:0] swt_clean;
  logic [WIDTH-1:0] swt_chg;
  logic             busy;

  modport master (
    output swt_raw,
    input  swt_clean,
    input  swt_chg,
    input  busy
  );

  modport slave (
    input  swt_raw,
    output swt_clean,
    output swt_chg,
    output busy
  );

endinterface

// File: rtl/swt_debounce_bit.sv
// One switch bit: two-flop synchronizer followed by a stable-time filter.
// Strobe and pending flags are only built with SWT_DEBOUNCE_CHG_EN.
module swt_debounce_bit
  import swt_pkg::*;
#(
  parameter int unsigned CNT_MAX = SWT_CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic chg,
  output logic pend
);

  localparam int unsigned     CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_clean;
  logic [CNT_W-1:0] r_cnt;
  swt_state_t       r_state;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clean_nxt;
  swt_state_t       w_state_nxt;

  // Plain two-flop synchronizer on the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
    end
  end

  // Any mismatch-free cycle during PEND is a bounce and abandons the count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    case (r_state)
      STABLE: begin
        if (r_s2 != r_clean) begin
          w_state_nxt = PEND;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PEND: begin
        if (r_s2 == r_clean) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
          w_clean_nxt = r_s2;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign clean = r_clean;

`ifdef SWT_DEBOUNCE_CHG_EN
  logic r_chg;
  logic r_pend;

  // The clean level only moves on an accepted toggle, so its edge is the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chg  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_chg  <= (w_clean_nxt != r_clean);
      r_pend <= (w_cnt_nxt != '0);
    end
  end

  assign chg  = r_chg;
  assign pend = r_pend;
`else
  assign chg  = 1'b0;
  assign pend = 1'b0;
`endif

endmodule

// File: rtl/swt_debounce.sv
// Debounces WIDTH slide switches for the adder operands.
// Optional change strobe and busy flag: SWT_DEBOUNCE_CHG_EN.
module swt_debounce
  import swt_pkg::*;
#(
  parameter int unsigned WIDTH   = SWT_WIDTH,
  parameter int unsigned CNT_MAX = SWT_CNT_MAX_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  swt_debounce_if.slave  bus
);

  logic [WIDTH-1:0] w_pend;

  // Bits are filtered fully independently.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    swt_debounce_bit #(
      .CNT_MAX (CNT_MAX)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.swt_raw[i]),
      .clean (bus.swt_clean[i]),
      .chg   (bus.swt_chg[i]),
      .pend  (w_pend[i])
    );
  end

  assign bus.busy = |w_pend;

endmodule

// File: tb/tb_swt_debounce.sv
// Directed bench for swt_debounce with CNT_MAX = 8; adapts to SWT_DEBOUNCE_CHG_EN.
module tb_swt_debounce;
  import swt_pkg::*;

`ifdef SWT_DEBOUNCE_CHG_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  swt_debounce_if #(.WIDTH(SWT_WIDTH)) u_if ();

  swt_debounce #(
    .WIDTH   (SWT_WIDTH),
    .CNT_MAX (SWT_CNT_MAX_SIM)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic expect4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare all outputs 1 time unit later.
  task automatic step(input string tag, input logic [3:0] e_clean,
                      input logic [3:0] e_chg, input logic e_busy);
    @(posedge clk);
    #1;
    expect4({tag, " clean"}, u_if.swt_clean, e_clean);
    expect4({tag, " chg"},   u_if.swt_chg,   CHG_EN ? e_chg : 4'b0000);
    expect4({tag, " busy"},  {3'b000, u_if.busy}, {3'b000, CHG_EN ? e_busy : 1'b0});
  endtask

  initial begin
    rst = 1'b1;
    u_if.swt_raw = 4'b0000;

    // Reset held three cycles.
    for (int k = 0; k < 3; k++) step("reset", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;

    // Clean rising edge on bit 0.
    u_if.swt_raw = 4'b0001;
    for (int e = 1; e <= 11; e++)
      step("clean_edge", (e >= 10) ? 4'b0001 : 4'b0000,
           (e == 10) ? 4'b0001 : 4'b0000, (e >= 3 && e <= 9));

    // Bit 1: high 5, low 2, then high and hold.
    for (int e = 1; e <= 18; e++) begin
      u_if.swt_raw = {2'b00, (e <= 5 || e >= 8), 1'b1};
      step("bounce", (e >= 17) ? 4'b0011 : 4'b0001,
           (e == 17) ? 4'b0010 : 4'b0000,
           ((e >= 3 && e <= 7) || (e >= 10 && e <= 16)));
    end

    // Simultaneous change on all bits from a reset state.
    rst = 1'b1;
    u_if.swt_raw = 4'b0000;
    for (int k = 0; k < 2; k++) step("reset2", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    u_if.swt_raw = 4'b1111;
    for (int e = 1; e <= 11; e++)
      step("simul", (e >= 10) ? 4'b1111 : 4'b0000,
           (e == 10) ? 4'b1111 : 4'b0000, (e >= 3 && e <= 9));

    // Reset four cycles into a pending bit-2 change.
    rst = 1'b1;
    u_if.swt_raw = 4'b0000;
    for (int k = 0; k < 2; k++) step("reset3", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    u_if.swt_raw = 4'b0100;
    for (int e = 1; e <= 6; e++)
      step("pend_pre", 4'b0000, 4'b0000, (e >= 3));
    rst = 1'b1;
    for (int k = 0; k < 2; k++) step("pend_rst", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 11; e++)
      step("pend_reaccept", (e >= 10) ? 4'b0100 : 4'b0000,
           (e == 10) ? 4'b0100 : 4'b0000, (e >= 3 && e <= 9));

    // Falling edge on bit 2.
    u_if.swt_raw = 4'b0000;
    for (int e = 1; e <= 11; e++)
      step("fall", (e >= 10) ? 4'b0000 : 4'b0100,
           (e == 10) ? 4'b0100 : 4'b0000, (e >= 3 && e <= 9));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
